// File: rtl/z80_pkg.sv
// Shared types for the Z80 bus-cycle sequencer:
// machine-cycle kinds, T-state encoding and the default I/O wait count.
package z80_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        MEM_RD = 3'd1,
        MEM_WR = 3'd2,
        IO_RD  = 3'd3,
        IO_WR  = 3'd4
    } cycle_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        T1     = 3'd1,
        T2     = 3'd2,
        TW     = 3'd3,
        T3     = 3'd4,
        T4     = 3'd5,
        BUSGNT = 3'd6
    } tstate_t;

    localparam int unsigned IO_AUTO_WAIT_DEF = 1;

    // Unknown request codes run as a plain memory read.
    function automatic cycle_t decode_type(input logic [2:0] t);
        case (t)
            3'd0:    return FETCH;
            3'd2:    return MEM_WR;
            3'd3:    return IO_RD;
            3'd4:    return IO_WR;
            default: return MEM_RD;
        endcase
    endfunction

endpackage

// File: rtl/z80_bus_cycle_seq.sv
// Z80 M-cycle sequencer: turns one request into T-state-accurate
// pin strobes, honours WAIT_L and hands the bus over on BUSREQ_L.
module z80_bus_cycle_seq
    import z80_pkg::*;
#(
    parameter int unsigned IO_AUTO_WAIT = IO_AUTO_WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  req_type,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic [15:0] rfsh_addr,
    output logic        ready,
    output logic        done,
    output logic [7:0]  rd_data,
    input  logic [7:0]  data_in,
    output logic [15:0] addr_out,
    output logic        addr_oe,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        M1_L,
    output logic        MREQ_L,
    output logic        IORQ_L,
    output logic        RD_L,
    output logic        WR_L,
    output logic        RFSH_L,
    input  logic        WAIT_L,
    input  logic        BUSREQ_L,
    output logic        BUSACK_L
);

    localparam logic [1:0] AUTO_W = 2'(IO_AUTO_WAIT);

    tstate_t     state, ns;
    cycle_t      cyc, n_cyc;
    logic [15:0] addr_q, n_addr;
    logic [7:0]  wdata_q, n_wdata;
    logic [1:0]  wcnt, n_wcnt;
    logic        is_io, final_st;

    logic        o_m1, o_mreq, o_iorq, o_rd, o_wr, o_rfsh;
    logic        o_aoe, o_doe, o_done, o_ready, o_busack, o_cap;
    logic        act, mid, strb;
    logic [15:0] o_addr;
    logic [7:0]  o_data;

    // Next T-state, forced-wait count and request latch.
    always_comb begin
        ns       = state;
        n_cyc    = cyc;
        n_addr   = addr_q;
        n_wdata  = wdata_q;
        n_wcnt   = wcnt;
        is_io    = (cyc == IO_RD) || (cyc == IO_WR);
        final_st = (state == IDLE) || (state == T4) ||
                   (state == T3 && cyc != FETCH);
        unique case (state)
            T1: ns = T2;
            T2: begin
                if (is_io && AUTO_W != 2'd0) begin
                    ns     = TW;
                    n_wcnt = AUTO_W - 2'd1;
                end else if (!WAIT_L) begin
                    ns = TW;
                end else begin
                    ns = T3;
                end
            end
            TW: begin
                if (wcnt != 2'd0) begin
                    n_wcnt = wcnt - 2'd1;
                end else if (WAIT_L) begin
                    ns = T3;
                end
            end
            T3:      if (cyc == FETCH) ns = T4;
            BUSGNT:  if (BUSREQ_L) ns = IDLE;
            default: ;
        endcase
        if (final_st) begin
            if (!BUSREQ_L) begin
                ns = BUSGNT;
            end else if (req) begin
                ns      = T1;
                n_cyc   = decode_type(req_type);
                n_addr  = req_addr;
                n_wdata = req_wdata;
            end else begin
                ns = IDLE;
            end
        end
    end

    // Pin values for the T-state being entered.
    always_comb begin
        act      = (ns == T1) || (ns == T2) || (ns == TW) ||
                   (ns == T3) || (ns == T4);
        mid      = (ns == T1) || (ns == T2) || (ns == TW);
        strb     = (ns == T2) || (ns == TW) || (ns == T3);
        o_m1     = 1'b1;
        o_mreq   = 1'b1;
        o_iorq   = 1'b1;
        o_rd     = 1'b1;
        o_wr     = 1'b1;
        o_rfsh   = 1'b1;
        o_doe    = 1'b0;
        o_aoe    = act;
        o_addr   = addr_out;
        o_data   = data_out;
        o_cap    = 1'b0;
        o_done   = (ns == T3);
        if (act) o_addr = n_addr;
        unique case (n_cyc)
            FETCH: begin
                o_done = (ns == T4);
                o_cap  = (ns == T3);
                if (mid) begin
                    o_m1   = 1'b0;
                    o_mreq = 1'b0;
                    o_rd   = 1'b0;
                end
                if (ns == T3) o_mreq = 1'b0;
                if (ns == T3 || ns == T4) begin
                    o_rfsh = 1'b0;
                    o_addr = rfsh_addr;
                end
            end
            MEM_WR: begin
                o_mreq = !act;
                o_wr   = !strb;
                o_doe  = act;
                if (act) o_data = n_wdata;
            end
            IO_RD: begin
                o_iorq = !strb;
                o_rd   = !strb;
                o_cap  = (ns == T3);
            end
            IO_WR: begin
                o_iorq = !strb;
                o_wr   = !strb;
                o_doe  = act;
                if (act) o_data = n_wdata;
            end
            default: begin
                o_mreq = !act;
                o_rd   = !act;
                o_cap  = (ns == T3);
            end
        endcase
        o_ready  = (ns == IDLE) || o_done;
        o_busack = (ns != BUSGNT);
    end

    // State, request latch and registered pin outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cyc      <= FETCH;
            addr_q   <= '0;
            wdata_q  <= '0;
            wcnt     <= '0;
            M1_L     <= 1'b1;
            MREQ_L   <= 1'b1;
            IORQ_L   <= 1'b1;
            RD_L     <= 1'b1;
            WR_L     <= 1'b1;
            RFSH_L   <= 1'b1;
            BUSACK_L <= 1'b1;
            addr_oe  <= 1'b0;
            data_oe  <= 1'b0;
            done     <= 1'b0;
            ready    <= 1'b1;
            rd_data  <= '0;
            addr_out <= '0;
            data_out <= '0;
        end else begin
            state    <= ns;
            cyc      <= n_cyc;
            addr_q   <= n_addr;
            wdata_q  <= n_wdata;
            wcnt     <= n_wcnt;
            M1_L     <= o_m1;
            MREQ_L   <= o_mreq;
            IORQ_L   <= o_iorq;
            RD_L     <= o_rd;
            WR_L     <= o_wr;
            RFSH_L   <= o_rfsh;
            BUSACK_L <= o_busack;
            addr_oe  <= o_aoe;
            data_oe  <= o_doe;
            done     <= o_done;
            ready    <= o_ready;
            addr_out <= o_addr;
            data_out <= o_data;
            if (o_cap) rd_data <= data_in;
        end
    end

endmodule

// File: tb/tb_z80_bus_cycle_seq.sv
// Self-checking bench for z80_bus_cycle_seq: per-clock vector table
// with a scoreboard queue, plus reset-in-cycle hand sequences.
module tb_z80_bus_cycle_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [2:0]  req_type;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic [15:0] rfsh_addr;
    logic        ready, done;
    logic [7:0]  rd_data, data_in, data_out;
    logic [15:0] addr_out;
    logic        addr_oe, data_oe;
    logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L;
    logic        WAIT_L, BUSREQ_L, BUSACK_L;

    z80_bus_cycle_seq #(.IO_AUTO_WAIT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rfsh_addr(rfsh_addr), .ready(ready), .done(done),
        .rd_data(rd_data), .data_in(data_in), .addr_out(addr_out),
        .addr_oe(addr_oe), .data_out(data_out), .data_oe(data_oe),
        .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L),
        .WR_L(WR_L), .RFSH_L(RFSH_L), .WAIT_L(WAIT_L),
        .BUSREQ_L(BUSREQ_L), .BUSACK_L(BUSACK_L)
    );

    always #5 clk = ~clk;

    // ctl = {done, ready, BUSACK_L, addr_oe, data_oe}
    localparam logic [4:0] C_IDLE = 5'b01100;
    localparam logic [4:0] C_MID  = 5'b00110;
    localparam logic [4:0] C_MIDW = 5'b00111;
    localparam logic [4:0] C_FIN  = 5'b11110;
    localparam logic [4:0] C_FINW = 5'b11111;
    localparam logic [4:0] C_GNT  = 5'b00000;
    // strb = {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L}
    localparam logic [5:0] S_NONE = 6'b111111;
    localparam logic [5:0] S_F12  = 6'b001011;
    localparam logic [5:0] S_F3   = 6'b101110;
    localparam logic [5:0] S_F4   = 6'b111110;
    localparam logic [5:0] S_MRD  = 6'b101011;
    localparam logic [5:0] S_MW1  = 6'b101111;
    localparam logic [5:0] S_MWR  = 6'b101101;
    localparam logic [5:0] S_IORD = 6'b110011;
    localparam logic [5:0] S_IOWR = 6'b110101;

    typedef struct packed {
        logic        req;
        logic [2:0]  typ;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        wait_l;
        logic        busreq_l;
        logic [7:0]  din;
        logic [4:0]  ctl;
        logic [5:0]  strb;
        logic [15:0] xaddr;
        logic [7:0]  xdata;
        logic [7:0]  xrd;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t v(
        input logic r, input logic [2:0] t, input logic [15:0] a,
        input logic [7:0] w, input logic wl, input logic br,
        input logic [7:0] din, input logic [4:0] c, input logic [5:0] s,
        input logic [15:0] xa, input logic [7:0] xd, input logic [7:0] xr
    );
        vec_t x;
        x = '{r, t, a, w, wl, br, din, c, s, xa, xd, xr};
        return x;
    endfunction

    task automatic check(input vec_t e, input string name,
                         input bit ca, input bit cd);
        logic [4:0] gc;
        logic [5:0] gs;
        bit         bad;
        gc  = {done, ready, BUSACK_L, addr_oe, data_oe};
        gs  = {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L};
        bad = (gc !== e.ctl) || (gs !== e.strb) || (rd_data !== e.xrd) ||
              (ca && addr_out !== e.xaddr) || (cd && data_out !== e.xdata);
        n_chk++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s: got ctl=%b strb=%b addr=%h data=%h rd=%h; expected ctl=%b strb=%b addr=%h data=%h rd=%h",
                     name, gc, gs, addr_out, data_out, rd_data,
                     e.ctl, e.strb, e.xaddr, e.xdata, e.xrd);
        end
    endtask

    task automatic apply(input vec_t x, input string name);
        vec_t e;
        req       = x.req;
        req_type  = x.typ;
        req_addr  = x.addr;
        req_wdata = x.wdata;
        WAIT_L    = x.wait_l;
        BUSREQ_L  = x.busreq_l;
        data_in   = x.din;
        sb.push_back(x);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e, name, e.ctl[1], e.ctl[0]);
    endtask

    initial begin
        // fetch 0x0000, refresh 0x3F05, opcode 0x3E
        tbl.push_back(v(1,0,16'h0000,8'h00,1,1,8'h00, C_MID, S_F12, 16'h0000,8'h00,8'h00));
        tbl.push_back(v(0,0,16'h0000,8'h00,1,1,8'h00, C_MID, S_F12, 16'h0000,8'h00,8'h00));
        tbl.push_back(v(0,0,16'h0000,8'h00,1,1,8'h3E, C_MID, S_F3,  16'h3F05,8'h00,8'h3E));
        tbl.push_back(v(0,0,16'h0000,8'h00,1,1,8'h00, C_FIN, S_F4,  16'h3F05,8'h00,8'h3E));
        tbl.push_back(v(0,0,16'h0000,8'h00,1,1,8'h00, C_IDLE,S_NONE,16'h0000,8'h00,8'h3E));
        // memory write with two wait states
        tbl.push_back(v(1,2,16'h8000,8'hA5,1,1,8'h00, C_MIDW,S_MW1, 16'h8000,8'hA5,8'h3E));
        tbl.push_back(v(0,2,16'h8000,8'hA5,1,1,8'h00, C_MIDW,S_MWR, 16'h8000,8'hA5,8'h3E));
        tbl.push_back(v(0,2,16'h8000,8'hA5,0,1,8'h00, C_MIDW,S_MWR, 16'h8000,8'hA5,8'h3E));
        tbl.push_back(v(0,2,16'h8000,8'hA5,0,1,8'h00, C_MIDW,S_MWR, 16'h8000,8'hA5,8'h3E));
        tbl.push_back(v(0,2,16'h8000,8'hA5,1,1,8'h00, C_FINW,S_MWR, 16'h8000,8'hA5,8'h3E));
        tbl.push_back(v(0,2,16'h8000,8'hA5,1,1,8'h00, C_IDLE,S_NONE,16'h0000,8'h00,8'h3E));
        // I/O read port 0xFE, one forced wait
        tbl.push_back(v(1,3,16'h00FE,8'h00,1,1,8'h00, C_MID, S_NONE,16'h00FE,8'h00,8'h3E));
        tbl.push_back(v(0,3,16'h00FE,8'h00,1,1,8'h00, C_MID, S_IORD,16'h00FE,8'h00,8'h3E));
        tbl.push_back(v(0,3,16'h00FE,8'h00,1,1,8'h00, C_MID, S_IORD,16'h00FE,8'h00,8'h3E));
        tbl.push_back(v(0,3,16'h00FE,8'h00,1,1,8'h77, C_FIN, S_IORD,16'h00FE,8'h00,8'h77));
        tbl.push_back(v(0,3,16'h00FE,8'h00,1,1,8'h00, C_IDLE,S_NONE,16'h0000,8'h00,8'h77));
        // back-to-back fetch then memory read, req held
        tbl.push_back(v(1,0,16'h1234,8'h00,1,1,8'h00, C_MID, S_F12, 16'h1234,8'h00,8'h77));
        tbl.push_back(v(1,1,16'h4000,8'h00,1,1,8'h00, C_MID, S_F12, 16'h1234,8'h00,8'h77));
        tbl.push_back(v(1,1,16'h4000,8'h00,1,1,8'h11, C_MID, S_F3,  16'h3F05,8'h00,8'h11));
        tbl.push_back(v(1,1,16'h4000,8'h00,1,1,8'h00, C_FIN, S_F4,  16'h3F05,8'h00,8'h11));
        tbl.push_back(v(1,1,16'h4000,8'h00,1,1,8'h99, C_MID, S_MRD, 16'h4000,8'h00,8'h11));
        tbl.push_back(v(0,1,16'h4000,8'h00,1,1,8'h00, C_MID, S_MRD, 16'h4000,8'h00,8'h11));
        tbl.push_back(v(0,1,16'h4000,8'h00,1,1,8'h5A, C_FIN, S_MRD, 16'h4000,8'h00,8'h5A));
        tbl.push_back(v(0,1,16'h4000,8'h00,1,1,8'h00, C_IDLE,S_NONE,16'h0000,8'h00,8'h5A));
        // bus request during memory read T2
        tbl.push_back(v(1,1,16'h2222,8'h00,1,1,8'h00, C_MID, S_MRD, 16'h2222,8'h00,8'h5A));
        tbl.push_back(v(0,1,16'h2222,8'h00,1,0,8'h00, C_MID, S_MRD, 16'h2222,8'h00,8'h5A));
        tbl.push_back(v(0,1,16'h2222,8'h00,1,0,8'hC3, C_FIN, S_MRD, 16'h2222,8'h00,8'hC3));
        tbl.push_back(v(1,0,16'h0100,8'h00,1,0,8'h00, C_GNT, S_NONE,16'h0000,8'h00,8'hC3));
        tbl.push_back(v(1,0,16'h0100,8'h00,1,0,8'h00, C_GNT, S_NONE,16'h0000,8'h00,8'hC3));
        tbl.push_back(v(0,0,16'h0100,8'h00,1,1,8'h00, C_IDLE,S_NONE,16'h0000,8'h00,8'hC3));
        // illegal type runs as memory read
        tbl.push_back(v(1,7,16'h0ABC,8'h00,1,1,8'h00, C_MID, S_MRD, 16'h0ABC,8'h00,8'hC3));
        tbl.push_back(v(0,7,16'h0ABC,8'h00,1,1,8'h00, C_MID, S_MRD, 16'h0ABC,8'h00,8'hC3));
        tbl.push_back(v(0,7,16'h0ABC,8'h00,1,1,8'h42, C_FIN, S_MRD, 16'h0ABC,8'h00,8'h42));
        tbl.push_back(v(0,7,16'h0ABC,8'h00,1,1,8'h00, C_IDLE,S_NONE,16'h0000,8'h00,8'h42));
        // I/O write: forced wait then one user wait
        tbl.push_back(v(1,4,16'h0055,8'h3C,1,1,8'h00, C_MIDW,S_NONE,16'h0055,8'h3C,8'h42));
        tbl.push_back(v(0,4,16'h0055,8'h3C,1,1,8'h00, C_MIDW,S_IOWR,16'h0055,8'h3C,8'h42));
        tbl.push_back(v(0,4,16'h0055,8'h3C,1,1,8'h00, C_MIDW,S_IOWR,16'h0055,8'h3C,8'h42));
        tbl.push_back(v(0,4,16'h0055,8'h3C,0,1,8'h00, C_MIDW,S_IOWR,16'h0055,8'h3C,8'h42));
        tbl.push_back(v(0,4,16'h0055,8'h3C,1,1,8'h00, C_FINW,S_IOWR,16'h0055,8'h3C,8'h42));
        tbl.push_back(v(0,4,16'h0055,8'h3C,1,1,8'h00, C_IDLE,S_NONE,16'h0000,8'h00,8'h42));

        rst       = 1'b1;
        req       = 1'b0;
        req_type  = 3'd0;
        req_addr  = 16'h0;
        req_wdata = 8'h0;
        rfsh_addr = 16'h3F05;
        data_in   = 8'h0;
        WAIT_L    = 1'b1;
        BUSREQ_L  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check(v(0,0,16'h0,8'h0,1,1,8'h0, C_IDLE,S_NONE,16'h0000,8'h00,8'h00),
              "reset_state", 1'b1, 1'b1);
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec[%0d]", i));

        // reset asserted in fetch T2
        apply(v(1,0,16'h5555,8'h00,1,1,8'h00, C_MID,S_F12,16'h5555,8'h00,8'h42), "rst_fetch_t1");
        apply(v(0,0,16'h5555,8'h00,1,1,8'h00, C_MID,S_F12,16'h5555,8'h00,8'h42), "rst_fetch_t2");
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({done, BUSACK_L, addr_oe, data_oe} !== 4'b0100 ||
            {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L} !== 6'b111111 ||
            rd_data !== 8'h00 || addr_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid: got done=%b busack=%b aoe=%b doe=%b strb=%b rd=%h addr=%h; expected 0 1 0 0 111111 00 0000",
                     done, BUSACK_L, addr_oe, data_oe,
                     {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L}, rd_data, addr_out);
        end
        @(negedge clk);
        rst = 1'b0;
        apply(v(0,0,16'h0,8'h00,1,1,8'h00, C_IDLE,S_NONE,16'h0000,8'h00,8'h00), "post_rst_idle");
        apply(v(1,1,16'h7001,8'h00,1,1,8'h00, C_MID, S_MRD, 16'h7001,8'h00,8'h00), "post_rst_t1");
        apply(v(0,1,16'h7001,8'h00,1,1,8'h00, C_MID, S_MRD, 16'h7001,8'h00,8'h00), "post_rst_t2");
        apply(v(0,1,16'h7001,8'h00,1,1,8'h6B, C_FIN, S_MRD, 16'h7001,8'h00,8'h6B), "post_rst_t3");
        apply(v(0,1,16'h7001,8'h00,1,1,8'h00, C_IDLE,S_NONE,16'h0000,8'h00,8'h6B), "post_rst_idle2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
